// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I load/store funct3 codes, LSU state type and decode helpers
package rv32_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, RMW_WR} lsu_state_t;
  function automatic logic f3_ok(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
  function automatic logic f3_mis(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b10 && off != 2'b00) || (f3[1:0] == 2'b01 && off[0]);
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte/half lane merge for sub-word stores and sign/zero extension for loads
module lsu_lane
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] st_word,
  output logic [31:0] ld_val
);
  logic [4:0] bsh, hsh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] mask, ins;
  assign bsh = {off, 3'b000};
  assign hsh = {off[1], 4'b0000};
  assign b = 8'(old_word >> bsh);
  assign h = 16'(old_word >> hsh);
  assign mask = funct3[0] ? 32'h0000_FFFF << hsh : 32'h0000_00FF << bsh;
  assign ins = funct3[0] ? {16'b0, wdata[15:0]} << hsh : {24'b0, wdata[7:0]} << bsh;
  assign st_word = (old_word & ~mask) | ins;
  always_comb
    ld_val = funct3 == F3_B  ? {{24{b[7]}}, b} :
             funct3 == F3_H  ? {{16{h[15]}}, h} :
             funct3 == F3_BU ? {24'b0, b} :
             funct3 == F3_HU ? {16'b0, h} : old_word;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: RV32I load/store unit onto word-only dmem; sb/sh via 2-cycle RMW; LSU_PERF_EN adds counters
module mem_lsu
  import rv32_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        misalign,
  output logic        dm_w_en,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_w_d,
  input  logic [31:0] dm_r_d
`ifdef LSU_PERF_EN
  ,
  output logic [CNT_W-1:0] n_loads,
  output logic [CNT_W-1:0] n_stores,
  output logic [CNT_W-1:0] n_rmw,
  output logic [CNT_W-1:0] n_misalign
`endif
);
  lsu_state_t state, nxt;
  logic [31:0] rmw_addr, rmw_data, st_word, ld_val;
  logic ok, mis, go, sub_st, w_st, in_wr;
  lsu_lane u_lane (
    .funct3  (req_funct3),
    .off     (req_addr[1:0]),
    .old_word(dm_r_d),
    .wdata   (req_wdata),
    .st_word (st_word),
    .ld_val  (ld_val)
  );
  assign ok = f3_ok(req_funct3);
  assign mis = ok & f3_mis(req_funct3, req_addr[1:0]);
  assign in_wr = state == RMW_WR;
  assign go = rst_n & req_valid & ~in_wr & ok & ~mis;
  assign sub_st = go & req_we & (req_funct3 != F3_W);
  assign w_st = go & req_we & (req_funct3 == F3_W);
  always_comb begin
    nxt = sub_st ? RMW_WR : IDLE;
    stall = sub_st;
    misalign = rst_n & req_valid & ~in_wr & mis;
    dm_w_en = rst_n & (in_wr | w_st);
    dm_addr = in_wr ? rmw_addr : {req_addr[31:2], 2'b00};
    dm_w_d = in_wr ? rmw_data : req_wdata;
    ld_data = (ok & ~mis) ? ld_val : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
    end else begin
      state <= nxt;
      if (sub_st) begin
        rmw_addr <= {req_addr[31:2], 2'b00};
        rmw_data <= st_word;
      end
    end
  end
`ifdef LSU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_loads <= '0;
      n_stores <= '0;
      n_rmw <= '0;
      n_misalign <= '0;
    end else begin
      if (go & ~req_we) n_loads <= n_loads + 1'b1;
      if (w_st | in_wr) n_stores <= n_stores + 1'b1;
      if (in_wr) n_rmw <= n_rmw + 1'b1;
      if (misalign) n_misalign <= n_misalign + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a byte-level memory model
module tb_mem_lsu;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [31:0] ld_data, dm_addr, dm_w_d, dm_r_d;
  logic stall, misalign, dm_w_en;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign dm_r_d = mem[dm_addr[7:2]];
  always @(posedge clk) if (dm_w_en) mem[dm_addr[7:2]] <= dm_w_d;
  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .ld_data(ld_data), .stall(stall), .misalign(misalign), .dm_w_en(dm_w_en),
    .dm_addr(dm_addr), .dm_w_d(dm_w_d), .dm_r_d(dm_r_d)
  );
  function automatic int sz(input logic [2:0] f);
    return f[1:0] == 2'd0 ? 1 : f[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic bit legal(input logic [2:0] f);
    return f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5;
  endfunction
  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [2:0] f,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w = old;
    int o = int'(a % 4);
    for (int i = 0; i < sz(f); i++) w[8*(o+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction
  function automatic logic [31:0] ref_ld(input logic [31:0] w, input logic [2:0] f, input logic [31:0] a);
    int o = int'(a % 4);
    logic [7:0] b = w[8*o +: 8];
    logic [15:0] h = w[16*(o/2) +: 16];
    case (f)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd4: return {24'b0, b};
      3'd5: return {16'b0, h};
      default: return w;
    endcase
  endfunction
  task automatic drive(input logic r, input logic v, input logic we, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst_n = r; req_valid = v; req_we = we; req_funct3 = f; req_addr = a; req_wdata = d;
    #2;
  endtask
  task automatic test_reset;
    drive(0, 1, 1, 3'd2, 32'h10, 32'hCAFEF00D);
    n_cmp++; if ({stall, dm_w_en, misalign} !== 3'b000) begin n_err++; $display("FAIL reset_ctl: got %b exp 000", {stall, dm_w_en, misalign}); end
    drive(1, 0, 0, 3'd2, 32'h10, 32'h0);
    n_cmp++; if (mem[4] !== 32'h0) begin n_err++; $display("FAIL reset_nowrite: got %h exp 00000000", mem[4]); end
    n_cmp++; if ({stall, dm_w_en, misalign} !== 3'b000) begin n_err++; $display("FAIL reset_idle: got %b exp 000", {stall, dm_w_en, misalign}); end
  endtask
  task automatic test_word;
    drive(1, 1, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    n_cmp++; if ({stall, dm_w_en, misalign} !== 3'b010) begin n_err++; $display("FAIL sw_ctl: got %b exp 010", {stall, dm_w_en, misalign}); end
    n_cmp++; if ({dm_addr, dm_w_d} !== {32'h10, 32'hDEADBEEF}) begin n_err++; $display("FAIL sw_bus: got %h/%h exp 00000010/deadbeef", dm_addr, dm_w_d); end
    ref_mem[4] = 32'hDEADBEEF;
    drive(1, 1, 0, 3'd2, 32'h10, 32'h0);
    n_cmp++; if (ld_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw: got %h exp deadbeef", ld_data); end
    n_cmp++; if ({stall, dm_w_en} !== 2'b00) begin n_err++; $display("FAIL lw_ctl: got %b exp 00", {stall, dm_w_en}); end
  endtask
  task automatic test_byte;
    drive(1, 1, 1, 3'd0, 32'h12, 32'h55);
    n_cmp++; if ({stall, dm_w_en, misalign} !== 3'b100) begin n_err++; $display("FAIL sb_c1: got %b exp 100", {stall, dm_w_en, misalign}); end
    drive(1, 1, 1, 3'd0, 32'h12, 32'h55);
    n_cmp++; if ({stall, dm_w_en, misalign} !== 3'b010) begin n_err++; $display("FAIL sb_c2: got %b exp 010", {stall, dm_w_en, misalign}); end
    n_cmp++; if ({dm_addr, dm_w_d} !== {32'h10, 32'hDE55BEEF}) begin n_err++; $display("FAIL sb_bus: got %h/%h exp 00000010/de55beef", dm_addr, dm_w_d); end
    ref_mem[4] = 32'hDE55BEEF;
    drive(1, 1, 0, 3'd0, 32'h12, 32'h0);
    n_cmp++; if (ld_data !== 32'h55) begin n_err++; $display("FAIL lb: got %h exp 00000055", ld_data); end
    drive(1, 1, 0, 3'd4, 32'h13, 32'h0);
    n_cmp++; if (ld_data !== 32'hDE) begin n_err++; $display("FAIL lbu: got %h exp 000000de", ld_data); end
  endtask
  task automatic test_half;
    drive(1, 1, 1, 3'd2, 32'h20, 32'h0000F00D);
    ref_mem[8] = 32'h0000F00D;
    drive(1, 1, 0, 3'd1, 32'h20, 32'h0);
    n_cmp++; if (ld_data !== 32'hFFFFF00D) begin n_err++; $display("FAIL lh: got %h exp fffff00d", ld_data); end
    drive(1, 1, 0, 3'd5, 32'h20, 32'h0);
    n_cmp++; if (ld_data !== 32'h0000F00D) begin n_err++; $display("FAIL lhu: got %h exp 0000f00d", ld_data); end
    drive(1, 1, 1, 3'd1, 32'h22, 32'h1234);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sh_stall: got %b exp 1", stall); end
    drive(1, 1, 1, 3'd1, 32'h22, 32'h1234);
    n_cmp++; if ({stall, dm_w_en, dm_w_d} !== {2'b01, 32'h1234F00D}) begin n_err++; $display("FAIL sh_wr: got %b%b/%h exp 01/1234f00d", stall, dm_w_en, dm_w_d); end
    ref_mem[8] = 32'h1234F00D;
    drive(1, 1, 0, 3'd2, 32'h20, 32'h0);
    n_cmp++; if (ld_data !== 32'h1234F00D) begin n_err++; $display("FAIL sh_lw: got %h exp 1234f00d", ld_data); end
  endtask
  task automatic test_misalign;
    drive(1, 1, 0, 3'd2, 32'h21, 32'h0);
    n_cmp++; if ({stall, dm_w_en, misalign, ld_data} !== {3'b001, 32'h0}) begin n_err++; $display("FAIL lw_mis: got %b/%h exp 001/00000000", {stall, dm_w_en, misalign}, ld_data); end
    drive(1, 1, 1, 3'd1, 32'h23, 32'hABCD);
    n_cmp++; if ({stall, dm_w_en, misalign, ld_data} !== {3'b001, 32'h0}) begin n_err++; $display("FAIL sh_mis: got %b/%h exp 001/00000000", {stall, dm_w_en, misalign}, ld_data); end
    drive(1, 0, 0, 3'd0, 32'h20, 32'h0);
    n_cmp++; if ({stall, dm_w_en, misalign} !== 3'b000) begin n_err++; $display("FAIL mis_after: got %b exp 000", {stall, dm_w_en, misalign}); end
    n_cmp++; if (mem[8] !== 32'h1234F00D) begin n_err++; $display("FAIL mis_mem: got %h exp 1234f00d", mem[8]); end
  endtask
  task automatic test_noop;
    drive(1, 1, 1, 3'd3, 32'h20, 32'h99999999);
    n_cmp++; if ({stall, dm_w_en, misalign, ld_data} !== {3'b000, 32'h0}) begin n_err++; $display("FAIL noop: got %b/%h exp 000/00000000", {stall, dm_w_en, misalign}, ld_data); end
    drive(1, 1, 0, 3'd7, 32'h20, 32'h0);
    n_cmp++; if ({misalign, ld_data} !== 33'h0) begin n_err++; $display("FAIL noop_ld: got %b/%h exp 0/00000000", misalign, ld_data); end
  endtask
  task automatic test_back_to_back;
    drive(1, 1, 1, 3'd2, 32'h30, 32'h0);
    drive(1, 1, 1, 3'd0, 32'h30, 32'hAA);
    drive(1, 1, 1, 3'd0, 32'h30, 32'hAA);
    n_cmp++; if ({dm_w_en, dm_w_d} !== {1'b1, 32'h000000AA}) begin n_err++; $display("FAIL b2b_1: got %b/%h exp 1/000000aa", dm_w_en, dm_w_d); end
    drive(1, 1, 1, 3'd0, 32'h31, 32'hBB);
    n_cmp++; if ({stall, dm_w_en} !== 2'b10) begin n_err++; $display("FAIL b2b_2stall: got %b exp 10", {stall, dm_w_en}); end
    drive(1, 1, 1, 3'd0, 32'h31, 32'hBB);
    n_cmp++; if ({dm_w_en, dm_w_d} !== {1'b1, 32'h0000BBAA}) begin n_err++; $display("FAIL b2b_2: got %b/%h exp 1/0000bbaa", dm_w_en, dm_w_d); end
    ref_mem[12] = 32'h0000BBAA;
  endtask
  task automatic test_rmw_reset;
    drive(1, 1, 1, 3'd2, 32'h40, 32'h11223344);
    ref_mem[16] = 32'h11223344;
    drive(1, 1, 1, 3'd0, 32'h40, 32'hFF);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rr_stall: got %b exp 1", stall); end
    drive(0, 1, 1, 3'd0, 32'h40, 32'hFF);
    n_cmp++; if ({stall, dm_w_en} !== 2'b00) begin n_err++; $display("FAIL rr_abort: got %b exp 00", {stall, dm_w_en}); end
    drive(1, 1, 0, 3'd2, 32'h40, 32'h0);
    n_cmp++; if ({stall, dm_w_en, ld_data} !== {2'b00, 32'h11223344}) begin n_err++; $display("FAIL rr_idle: got %b/%h exp 00/11223344", {stall, dm_w_en}, ld_data); end
  endtask
  task automatic test_random;
    logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    logic v, we, m, g;
    logic [2:0] f;
    logic [31:0] a, d, e;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 8) != 0;
      we = 1'($urandom % 2);
      f = we ? st_f3[$urandom % 6] : 3'($urandom % 8);
      a = $urandom % 256;
      d = $urandom;
      drive(1, v, we, f, a, d);
      m = v && legal(f) && (a % sz(f) != 0);
      g = v && legal(f) && !m;
      if (!v) begin
        n_cmp++; if ({stall, dm_w_en, misalign, dm_addr} !== {3'b000, a & 32'hFFFF_FFFC}) begin n_err++; $display("FAIL rnd_idle: got %b/%h exp 000/%h", {stall, dm_w_en, misalign}, dm_addr, a & 32'hFFFF_FFFC); end
      end else if (!we) begin
        e = g ? ref_ld(ref_mem[a[7:2]], f, a) : 32'h0;
        n_cmp++; if ({stall, dm_w_en, misalign, ld_data} !== {2'b00, m, e}) begin n_err++; $display("FAIL rnd_ld f3=%0d a=%h: got %b/%h exp 00%b/%h", f, a, {stall, dm_w_en, misalign}, ld_data, m, e); end
      end else if (g && f == 3'd2) begin
        n_cmp++; if ({stall, dm_w_en, misalign, dm_w_d} !== {3'b010, d}) begin n_err++; $display("FAIL rnd_sw a=%h: got %b/%h exp 010/%h", a, {stall, dm_w_en, misalign}, dm_w_d, d); end
        ref_mem[a[7:2]] = d;
      end else if (g) begin
        n_cmp++; if ({stall, dm_w_en, misalign} !== 3'b100) begin n_err++; $display("FAIL rnd_sub1 a=%h: got %b exp 100", a, {stall, dm_w_en, misalign}); end
        e = ref_merge(ref_mem[a[7:2]], f, a, d);
        drive(1, 1'($urandom % 2), we, f, a, d);
        n_cmp++; if ({stall, dm_w_en, dm_addr, dm_w_d} !== {2'b01, a & 32'hFFFF_FFFC, e}) begin n_err++; $display("FAIL rnd_sub2 a=%h: got %b/%h/%h exp 01/%h/%h", a, {stall, dm_w_en}, dm_addr, dm_w_d, a & 32'hFFFF_FFFC, e); end
        ref_mem[a[7:2]] = e;
      end else begin
        n_cmp++; if ({stall, dm_w_en, misalign} !== {2'b00, m}) begin n_err++; $display("FAIL rnd_drop f3=%0d a=%h: got %b exp 00%b", f, a, {stall, dm_w_en, misalign}, m); end
      end
    end
    drive(1, 0, 0, 3'd0, 32'h0, 32'h0);
    for (int w = 0; w < 64; w++) begin
      n_cmp++; if (mem[w] !== ref_mem[w]) begin n_err++; $display("FAIL mem_final[%0d]: got %h exp %h", w, mem[w], ref_mem[w]); end
    end
  endtask
  initial begin
    for (int w = 0; w < 64; w++) begin
      mem[w] = 32'h0;
      ref_mem[w] = 32'h0;
    end
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_misalign;
    test_noop;
    test_back_to_back;
    test_rmw_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit between the MEM pipeline stage and the word-only data memory (`dmem`). It turns RV32I `lb/lh/lw/lbu/lhu/sb/sh/sw` into word accesses. Loads are sign- or zero-extended combinationally from the memory read port. Because the memory has no byte enables, `sb`/`sh` run as a two-cycle read-modify-write that stalls the pipeline for one cycle.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters. Used only when `LSU_PERF_EN` is defined.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, synchronous and active-low.
- `req_valid`  in  1: the MEM stage holds a memory instruction.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I funct3 (size, and signedness for loads).
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data (rs2), right-aligned.
- `ld_data`  out  32: extended load result.
- `stall`  out  1: holds the request and the upstream stages for this cycle.
- `misalign`  out  1: the current request is misaligned and is dropped.
- `dm_w_en`  out  1: write enable to `dmem`.
- `dm_addr`  out  32: word address to `dmem`, with bits [1:0] = 0.
- `dm_w_d`  out  32: write data to `dmem`.
- `dm_r_d`  in  32: combinational read data from `dmem`.

## Operation
- FSM states: `IDLE` and `RMW_WR`. Reset enters `IDLE`.
- Alignment rule:
  - `lw`/`sw` need `addr[1:0]==0`.
  - `lh`/`lhu`/`sh` need `addr[0]==0`.
  - Bytes are always aligned.
- A misaligned request:
  - `misalign=1` while `req_valid` holds.
  - No write, `ld_data=0`, no stall.
- Loads in `IDLE`:
  - `dm_addr = {req_addr[31:2],2'b00}`.
  - The byte or half is selected by `addr[1:0]` (little-endian).
  - `lb/lh` sign-extend; `lbu/lhu` zero-extend; `lw` passes through.
  - No stall.
- `sw` in `IDLE`: `dm_w_en=1`, `dm_w_d=req_wdata`. The write lands at the next edge. No stall.
- `sb`/`sh` in `IDLE`:
  - `stall=1` and `dm_w_en=0`.
  - The merged word (old `dm_r_d` with the target lane(s) replaced from `req_wdata[7:0]`/`[15:0]`) is captured into `rmw_data`.
  - The word address is captured into `rmw_addr`.
  - Next state is `RMW_WR`.
- `RMW_WR`:
  - `dm_w_en=1`, `dm_addr=rmw_addr`, `dm_w_d=rmw_data`, `stall=0`.
  - The still-presented request is ignored; it retires at this edge.
  - Always returns to `IDLE`.
- Funct3 values `3'b011`, `3'b110`, `3'b111`: treated as a no-op. No write, `ld_data=0`, `misalign=0`.
- `req_valid=0`: `dm_w_en=0`, `stall=0`, `misalign=0`. `dm_addr` still tracks `req_addr`.

## Timing
- Load latency: 0 cycles (combinational through `dmem`).
- `sw`: 1 cycle, no stall.
- `sb`/`sh`: 2 cycles, with `stall` high in exactly the first one.
- Reset values:
  - State `IDLE`.
  - `rmw_addr=0`, `rmw_data=0`.
  - While `rst_n=0`: `dm_w_en=0`, `stall=0`, `misalign=0`.
- Reset asserted in `RMW_WR`: the write is aborted (`dm_w_en` forced 0) and the FSM goes to `IDLE`.
- `req_valid` dropping while in `RMW_WR`: the write still completes. The FSM has already committed the store.
- Back-to-back sub-word stores: each takes 2 cycles. The second enters `IDLE` on the cycle after `RMW_WR`.
- A load following an `sb` to the same word sees the merged value, because the write lands before the load's cycle.

## Configuration
- `LSU_PERF_EN` defined: adds `CNT_W`-bit counters `n_loads`, `n_stores`, `n_rmw`, `n_misalign`, exposed as extra output ports.
  - Each increments once per retired request.
  - All reset to 0 and wrap at 2^CNT_W.
- `LSU_PERF_EN` undefined: no counters and no extra ports. Behaviour is otherwise identical.

## Structure
- Shared package `rv32_pkg` holds:
  - funct3 constants `F3_B/F3_H/F3_W/F3_BU/F3_HU`;
  - the enum `lsu_state_t {IDLE, RMW_WR}`.
- Sub-module `lsu_lane` (combinational): given funct3, `addr[1:0]`, old word and store data, produces the merged store word and the extended load value.

## Test plan
- `sw` to 0x10 with 0xDEADBEEF, then `lw` 0x10 -> `dm_w_en` for 1 cycle, `stall=0`, `ld_data=0xDEADBEEF`.
- Word 0x10 = 0xDEADBEEF; `sb` 0x12 with 0x55 -> `stall` for 1 cycle, then write of 0xDE55BEEF; `lb` 0x12 -> 0x00000055; `lbu` 0x13 -> 0x000000DE.
- Word 0x20 = 0x0000F00D; `lh` 0x20 -> 0xFFFFF00D, `lhu` 0x20 -> 0x0000F00D; `sh` 0x22 with 0x1234 -> word 0x1234F00D.
- `lw` 0x21 and `sh` 0x23 -> `misalign=1`, no `dm_w_en`, `ld_data=0`, `stall=0`.
- Back-to-back `sb` to 0x30 then 0x31 -> two 2-cycle sequences; the second merge includes the first byte.
- `rst_n=0` while in `RMW_WR` -> no write occurs, FSM is in `IDLE`, and the memory word is unchanged.
